mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Three-way memory port arbiter (dcache > icache > prefetch, with anti-starvation
// promotion for prefetch) plus a tag-indexed owner table that routes completions.
module mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 7
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      dc_command,
  input  logic [XLEN-1:0] dc_addr,
  input  logic [63:0]     dc_data,
  input  logic [1:0]      ic_command,
  input  logic [XLEN-1:0] ic_addr,
  input  logic [1:0]      pf_command,
  input  logic [XLEN-1:0] pf_addr,
  input  logic [3:0]      mem2proc_response,
  input  logic [3:0]      mem2proc_tag,
  input  logic [63:0]     mem2proc_data,
  output logic [1:0]      proc2mem_command,
  output logic [XLEN-1:0] proc2mem_addr,
  output logic [63:0]     proc2mem_data,
  output logic [3:0]      dc_response,
  output logic [3:0]      ic_response,
  output logic [3:0]      pf_response,
  output logic [3:0]      dc_tag,
  output logic [3:0]      ic_tag,
  output logic [63:0]     mem_data,
  output logic            give_way
);

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [2:0] LIMIT     = 3'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DC   = 2'd1,
    OWN_IC   = 2'd2,
    OWN_PF   = 2'd3
  } owner_e;

  owner_e     owner_tbl [16];
  owner_e     winner;
  owner_e     cpl_owner;
  logic [2:0] starve_cnt;
  logic       err_dup;
  logic       dc_req, ic_req, pf_req, promote;
  logic       cpl_hit, rec_grant, dup_hit;

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v >= LIMIT) ? LIMIT : v + 3'd1;
  endfunction

  assign dc_req  = (dc_command != BUS_NONE);
  assign ic_req  = (ic_command != BUS_NONE);
  assign pf_req  = (pf_command != BUS_NONE);
  assign promote = (starve_cnt == LIMIT);

  // Grant selection and request/response steering, all same-cycle
  always_comb begin
    winner           = OWN_NONE;
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    dc_response      = 4'd0;
    ic_response      = 4'd0;
    pf_response      = 4'd0;
    if (dc_req) begin
      winner           = OWN_DC;
      proc2mem_command = dc_command;
      proc2mem_addr    = dc_addr;
      proc2mem_data    = dc_data;
      dc_response      = mem2proc_response;
    end else if (pf_req && (promote || !ic_req)) begin
      winner           = OWN_PF;
      proc2mem_command = pf_command;
      proc2mem_addr    = pf_addr;
      pf_response      = mem2proc_response;
    end else if (ic_req) begin
      winner           = OWN_IC;
      proc2mem_command = ic_command;
      proc2mem_addr    = ic_addr;
      ic_response      = mem2proc_response;
    end
  end

  assign give_way = pf_req && (winner != OWN_PF);
  assign mem_data = mem2proc_data;

  // Completion routing from the owner table
  assign cpl_owner = owner_tbl[mem2proc_tag];
  assign cpl_hit   = (mem2proc_tag != 4'd0) && (cpl_owner != OWN_NONE);

  always_comb begin
    dc_tag = 4'd0;
    ic_tag = 4'd0;
    if (cpl_hit) begin
      if (cpl_owner == OWN_DC) dc_tag = mem2proc_tag;
      else                     ic_tag = mem2proc_tag;
    end
  end

  // A completion clearing the same tag in this cycle does not count as a duplicate
  assign rec_grant = (proc2mem_command == BUS_LOAD) && (mem2proc_response != 4'd0);
  assign dup_hit   = rec_grant && (owner_tbl[mem2proc_response] != OWN_NONE) &&
                     !(cpl_hit && (mem2proc_tag == mem2proc_response));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) owner_tbl[i] <= OWN_NONE;
      err_dup <= 1'b0;
    end else begin
      if (cpl_hit)   owner_tbl[mem2proc_tag]      <= OWN_NONE;
      if (rec_grant) owner_tbl[mem2proc_response] <= winner;
      err_dup <= err_dup | dup_hit;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                          starve_cnt <= 3'd0;
    else if (!pf_req || winner == OWN_PF) starve_cnt <= 3'd0;
    else if (give_way)                   starve_cnt <= sat_inc(starve_cnt);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: priority, promotion, owner table routing, reset.
module tb_mem_arbiter;

  localparam int XLEN = 32;
  localparam logic [1:0] NONE = 2'd0, LOAD = 2'd1, STORE = 2'd2;

  logic            clock = 1'b0;
  logic            reset;
  logic [1:0]      dc_command, ic_command, pf_command;
  logic [XLEN-1:0] dc_addr, ic_addr, pf_addr;
  logic [63:0]     dc_data, mem2proc_data;
  logic [3:0]      mem2proc_response, mem2proc_tag;
  logic [1:0]      proc2mem_command;
  logic [XLEN-1:0] proc2mem_addr;
  logic [63:0]     proc2mem_data, mem_data;
  logic [3:0]      dc_response, ic_response, pf_response, dc_tag, ic_tag;
  logic            give_way;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(7)) dut (
    .clock(clock), .reset(reset),
    .dc_command(dc_command), .dc_addr(dc_addr), .dc_data(dc_data),
    .ic_command(ic_command), .ic_addr(ic_addr),
    .pf_command(pf_command), .pf_addr(pf_addr),
    .mem2proc_response(mem2proc_response), .mem2proc_tag(mem2proc_tag),
    .mem2proc_data(mem2proc_data),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data),
    .dc_response(dc_response), .ic_response(ic_response), .pf_response(pf_response),
    .dc_tag(dc_tag), .ic_tag(ic_tag), .mem_data(mem_data), .give_way(give_way)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic idle();
    dc_command = NONE; ic_command = NONE; pf_command = NONE;
    mem2proc_response = 4'd0; mem2proc_tag = 4'd0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    dc_addr = 32'h100; ic_addr = 32'h200; pf_addr = 32'h300;
    dc_data = 64'hAAAA_5555_0000_1111; mem2proc_data = 64'h0;
    mem2proc_tag = 4'd3;
    #12;
    check_eq("rst_tbl3", 64'(dut.owner_tbl[3]), 64'd0);
    check_eq("rst_starve", 64'(dut.starve_cnt), 64'd0);
    check_eq("rst_err_dup", 64'(dut.err_dup), 64'd0);
    check_eq("rst_dc_tag", 64'(dc_tag), 64'd0);
    check_eq("rst_ic_tag", 64'(ic_tag), 64'd0);
    tick();
    reset = 1'b1;
    idle();
    #1;
    check_eq("idle_cmd", 64'(proc2mem_command), 64'(NONE));
    check_eq("idle_addr", 64'(proc2mem_addr), 64'd0);
    check_eq("idle_data", 64'(proc2mem_data), 64'd0);

    // dcache beats icache; load recorded against tag 3
    tick();
    dc_command = LOAD; ic_command = LOAD; mem2proc_response = 4'd3;
    #1;
    check_eq("r19_cmd", 64'(proc2mem_command), 64'(LOAD));
    check_eq("r19_addr", 64'(proc2mem_addr), 64'h100);
    check_eq("r19_pdata", proc2mem_data, 64'hAAAA_5555_0000_1111);
    check_eq("r19_dc_resp", 64'(dc_response), 64'd3);
    check_eq("r19_ic_resp", 64'(ic_response), 64'd0);
    check_eq("r19_pf_resp", 64'(pf_response), 64'd0);
    tick();
    idle();
    check_eq("r19_tbl3", 64'(dut.owner_tbl[3]), 64'd1);
    mem2proc_tag = 4'd3; mem2proc_data = 64'hDEAD_BEEF_0123_4567;
    #1;
    check_eq("r19_dc_tag", 64'(dc_tag), 64'd3);
    check_eq("r19_ic_tag", 64'(ic_tag), 64'd0);
    check_eq("r19_mem_data", mem_data, 64'hDEAD_BEEF_0123_4567);
    tick();
    idle();
    check_eq("r19_tbl3_clr", 64'(dut.owner_tbl[3]), 64'd0);

    // prefetch starved by icache for 7 cycles, then promoted
    pf_command = LOAD; ic_command = LOAD; mem2proc_response = 4'd0;
    for (int i = 0; i < 7; i++) begin
      #1;
      check_eq($sformatf("r20_gw_c%0d", i), 64'(give_way), 64'd1);
      check_eq($sformatf("r20_addr_c%0d", i), 64'(proc2mem_addr), 64'h200);
      tick();
    end
    check_eq("r20_starve7", 64'(dut.starve_cnt), 64'd7);
    dc_command = LOAD;
    #1;
    check_eq("r20_dc_preempt", 64'(proc2mem_addr), 64'h100);
    check_eq("r20_dc_gw", 64'(give_way), 64'd1);
    dc_command = NONE; mem2proc_response = 4'd7;
    #1;
    check_eq("r20_pf_addr", 64'(proc2mem_addr), 64'h300);
    check_eq("r20_pf_resp", 64'(pf_response), 64'd7);
    check_eq("r20_ic_resp", 64'(ic_response), 64'd0);
    check_eq("r20_gw_c7", 64'(give_way), 64'd0);
    tick();
    idle();
    check_eq("r20_starve_clr", 64'(dut.starve_cnt), 64'd0);
    check_eq("r20_tbl7", 64'(dut.owner_tbl[7]), 64'd3);
    mem2proc_tag = 4'd7;
    #1;
    check_eq("r20_pf_ic_tag", 64'(ic_tag), 64'd7);
    check_eq("r20_pf_dc_tag", 64'(dc_tag), 64'd0);
    tick();
    idle();

    // tag 5: prefetch completes while icache is granted the same tag
    pf_command = LOAD; mem2proc_response = 4'd5;
    #1;
    check_eq("r21_pf_resp", 64'(pf_response), 64'd5);
    tick();
    idle();
    check_eq("r21_tbl5_pf", 64'(dut.owner_tbl[5]), 64'd3);
    ic_command = LOAD; mem2proc_response = 4'd5; mem2proc_tag = 4'd5;
    #1;
    check_eq("r21_ic_tag", 64'(ic_tag), 64'd5);
    check_eq("r21_dc_tag", 64'(dc_tag), 64'd0);
    check_eq("r21_ic_resp", 64'(ic_response), 64'd5);
    tick();
    idle();
    check_eq("r21_tbl5_ic", 64'(dut.owner_tbl[5]), 64'd2);
    check_eq("r21_no_dup", 64'(dut.err_dup), 64'd0);
    mem2proc_tag = 4'd5;
    tick();
    idle();
    check_eq("r21_tbl5_clr", 64'(dut.owner_tbl[5]), 64'd0);

    // stores are not recorded
    dc_command = STORE; dc_addr = 32'h500; dc_data = 64'h1234_5678_9ABC_DEF0;
    mem2proc_response = 4'd9;
    #1;
    check_eq("r22_cmd", 64'(proc2mem_command), 64'(STORE));
    check_eq("r22_pdata", proc2mem_data, 64'h1234_5678_9ABC_DEF0);
    check_eq("r22_dc_resp", 64'(dc_response), 64'd9);
    tick();
    idle();
    check_eq("r22_tbl9", 64'(dut.owner_tbl[9]), 64'd0);
    mem2proc_tag = 4'd9;
    #1;
    check_eq("r22_dc_tag", 64'(dc_tag), 64'd0);
    check_eq("r22_ic_tag", 64'(ic_tag), 64'd0);
    check_eq("r22_idle_pdata", proc2mem_data, 64'd0);
    tick();
    idle();

    // rejected load, then reset discards an outstanding owner
    ic_command = LOAD; ic_addr = 32'h600; mem2proc_response = 4'd0;
    #1;
    check_eq("r23_ic_resp0", 64'(ic_response), 64'd0);
    tick();
    check_eq("r23_tbl0", 64'(dut.owner_tbl[0]), 64'd0);
    mem2proc_response = 4'd2;
    tick();
    idle();
    check_eq("r23_tbl2_ic", 64'(dut.owner_tbl[2]), 64'd2);
    #2 reset = 1'b0;
    #2;
    check_eq("r23_rst_tbl2", 64'(dut.owner_tbl[2]), 64'd0);
    tick();
    reset = 1'b1;
    mem2proc_tag = 4'd2;
    #1;
    check_eq("r23_ic_tag", 64'(ic_tag), 64'd0);
    check_eq("r23_dc_tag", 64'(dc_tag), 64'd0);
    tick();
    idle();

    // duplicate grant of tag 4
    dc_command = LOAD; mem2proc_response = 4'd4;
    tick();
    idle();
    check_eq("r24_tbl4_dc", 64'(dut.owner_tbl[4]), 64'd1);
    check_eq("r24_err_pre", 64'(dut.err_dup), 64'd0);
    ic_command = LOAD; mem2proc_response = 4'd4;
    tick();
    idle();
    check_eq("r24_err_dup", 64'(dut.err_dup), 64'd1);
    check_eq("r24_tbl4_ic", 64'(dut.owner_tbl[4]), 64'd2);
    tick();
    check_eq("r24_err_sticky", 64'(dut.err_dup), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
